audio_sample_scheduler: RTL

Per-frame sample scheduler that sits between the synth engine voice/mixer output and the I2S DAC serializer. It paces the synth engine with a one-request-per-stereo-frame handshake timed off iAUD_DACLRCK. It double-buffers the returned left/right pair and commits it to the serializer inputs only at frame start, so the serializer never sees a torn pair. It also handles underrun (late or missing data) and mute.

---
 rtl/audio_sample_scheduler.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/audio_sample_scheduler.sv
// rtl/audio_sample_scheduler.sv - per-frame stereo sample scheduler between synth engine and I2S serializer
//
// Paces the synth engine with one request per stereo frame, derived from the
// LR clock, double-buffers the returned left/right pair and commits it to the
// serializer only at frame start (LRCK falling edge), so the serializer never
// sees a torn pair. Late or missing data is reported as an underrun; mute
// zeros the committed pair.
//
// Parameters:
//   AUD_BIT_DEPTH  sample width (two's complement)
//   UNDERRUN_HOLD  1 = repeat last committed pair on underrun, 0 = commit zeros
//   CNT_W          width of the saturating underrun counter
//
// Ports:
//   iAUD_BCLK       in   bit clock, all logic on posedge
//   reset_reg_N     in   asynchronous active-low reset
//   iAUD_DACLRCK    in   LR clock (low = left half, high = right half)
//   i_mute          in   mute request, sampled at frame start
//   o_sample_req    out  request for the next stereo pair
//   i_sample_valid  in   qualifies i_lsample / i_rsample while requesting
//   i_lsample       in   left sample from the engine
//   i_rsample       in   right sample from the engine
//   o_lsound_out    out  committed left sample
//   o_rsound_out    out  committed right sample
//   o_frame_tick    out  one-cycle pulse at each commit
//   o_underrun      out  one-cycle pulse when a frame start finds no fresh pair
//   o_underrun_cnt  out  saturating underrun count
//
// Optional feature macro: AUDIO_SCHED_SOFTMUTE_EN
//   When defined, mute ramps an attenuation shift (0..8) once per frame start
//   instead of hard-zeroing the outputs.

module audio_sample_scheduler #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int UNDERRUN_HOLD = 1,
  parameter int CNT_W         = 16
) (
  input  logic                     iAUD_BCLK,
  input  logic                     reset_reg_N,
  input  logic                     iAUD_DACLRCK,
  input  logic                     i_mute,
  output logic                     o_sample_req,
  input  logic                     i_sample_valid,
  input  logic [AUD_BIT_DEPTH-1:0] i_lsample,
  input  logic [AUD_BIT_DEPTH-1:0] i_rsample,
  output logic [AUD_BIT_DEPTH-1:0] o_lsound_out,
  output logic [AUD_BIT_DEPTH-1:0] o_rsound_out,
  output logic                     o_frame_tick,
  output logic                     o_underrun,
  output logic [CNT_W-1:0]         o_underrun_cnt
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_SLOT = 2'd1,
    ST_REQ  = 2'd2,
    ST_HAVE = 2'd3
  } state_t;

  state_t                   state_q,  state_d;
  logic                     lrck_q;
  logic                     req_q,    req_d;
  logic                     tick_q,   tick_d;
  logic                     urun_q,   urun_d;
  logic [AUD_BIT_DEPTH-1:0] lstage_q, lstage_d;
  logic [AUD_BIT_DEPTH-1:0] rstage_q, rstage_d;
  logic [AUD_BIT_DEPTH-1:0] lsound_q, lsound_d;
  logic [AUD_BIT_DEPTH-1:0] rsound_q, rsound_d;
  logic [CNT_W-1:0]         cnt_q,    cnt_d;

  logic                     rise;
  logic                     fall;
  logic                     frame_start;
  logic                     commit;
  logic                     miss;
  logic [AUD_BIT_DEPTH-1:0] src_l;
  logic [AUD_BIT_DEPTH-1:0] src_r;

  // LRCK rising edge opens the request window; falling edge is frame start.
  assign rise        = iAUD_DACLRCK & ~lrck_q;
  assign fall        = ~iAUD_DACLRCK & lrck_q;
  // The very first fall after reset only aligns the FSM and is not a frame.
  assign frame_start = fall && (state_q != ST_SYNC);

`ifdef AUDIO_SCHED_SOFTMUTE_EN
  logic [3:0] atten_q, atten_d;

  always_comb begin
    atten_d = atten_q;
    if (frame_start) begin
      if (i_mute) begin
        if (atten_q < 4'd8) atten_d = atten_q + 4'd1;
      end else begin
        if (atten_q != 4'd0) atten_d = atten_q - 4'd1;
      end
    end
  end

  always_ff @(posedge iAUD_BCLK or negedge reset_reg_N) begin
    if (!reset_reg_N) atten_q <= 4'd0;
    else              atten_q <= atten_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    tick_d   = 1'b0;
    urun_d   = 1'b0;
    lstage_d = lstage_q;
    rstage_d = rstage_q;
    lsound_d = lsound_q;
    rsound_d = rsound_q;
    cnt_d    = cnt_q;
    commit   = 1'b0;
    miss     = 1'b0;
    src_l    = lstage_q;
    src_r    = rstage_q;

    case (state_q)
      ST_SYNC: begin
        if (fall) state_d = ST_SLOT;
      end
      ST_SLOT: begin
        // A frame start before any request window means nothing was fetched.
        if (fall) begin
          miss = 1'b1;
        end else if (rise) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
        end
      end
      ST_REQ: begin
        if (i_sample_valid) begin
          lstage_d = i_lsample;
          rstage_d = i_rsample;
          req_d    = 1'b0;
          if (fall) begin
            // Data arriving on the frame-start cycle bypasses staging.
            commit  = 1'b1;
            src_l   = i_lsample;
            src_r   = i_rsample;
            state_d = ST_SLOT;
          end else begin
            state_d = ST_HAVE;
          end
        end else if (fall) begin
          miss    = 1'b1;
          req_d   = 1'b0;
          state_d = ST_SLOT;
        end
      end
      ST_HAVE: begin
        if (fall) begin
          commit  = 1'b1;
          state_d = ST_SLOT;
        end
      end
      default: begin
        state_d = ST_SYNC;
        req_d   = 1'b0;
      end
    endcase

    if (miss) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end

    if (commit || miss) begin
      tick_d = 1'b1;
      urun_d = miss;
      // On a hold-policy underrun the staging pair is the last committed pair.
      if (miss && (UNDERRUN_HOLD == 0)) begin
        lsound_d = '0;
        rsound_d = '0;
      end else begin
`ifdef AUDIO_SCHED_SOFTMUTE_EN
        if (atten_d >= 4'd8) begin
          lsound_d = '0;
          rsound_d = '0;
        end else begin
          lsound_d = $unsigned($signed(src_l) >>> atten_d);
          rsound_d = $unsigned($signed(src_r) >>> atten_d);
        end
`else
        if (i_mute) begin
          lsound_d = '0;
          rsound_d = '0;
        end else begin
          lsound_d = src_l;
          rsound_d = src_r;
        end
`endif
      end
    end
  end

  always_ff @(posedge iAUD_BCLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q  <= ST_SYNC;
      lrck_q   <= 1'b0;
      req_q    <= 1'b0;
      tick_q   <= 1'b0;
      urun_q   <= 1'b0;
      lstage_q <= '0;
      rstage_q <= '0;
      lsound_q <= '0;
      rsound_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      lrck_q   <= iAUD_DACLRCK;
      req_q    <= req_d;
      tick_q   <= tick_d;
      urun_q   <= urun_d;
      lstage_q <= lstage_d;
      rstage_q <= rstage_d;
      lsound_q <= lsound_d;
      rsound_q <= rsound_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_sample_req   = req_q;
  assign o_frame_tick   = tick_q;
  assign o_underrun     = urun_q;
  assign o_lsound_out   = lsound_q;
  assign o_rsound_out   = rsound_q;
  assign o_underrun_cnt = cnt_q;

endmodule
